clock_timekeeper: RTL and testbench

- Upstream timekeeping stage for the 6-digit multiplexed display driver.
- Runs on the 1 kHz system tick and keeps hour/min/sec in binary. Each field is 6 bits, in range, and fed directly to the display driver's sec/min/hour inputs.
- Two raw push-buttons (mode, inc) are synchronized and debounced, then drive a set-time state machine.

---
 rtl/clock_timekeeper.sv | 243 ++++++++++++++++++++++++
 tb/tb_clock_timekeeper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_timekeeper.sv
// Purpose : HH:MM:SS timekeeper with debounced mode/inc buttons and a set-time state machine.
// Latency : sec_tick and the time fields update on the prescaler wrap edge; button press acts DEBOUNCE_MS+2 edges after first sample.
// Backpressure: none; free-running, outputs are always valid.
//
// Ports:
//   clk_1000hz  1 kHz system clock
//   rst_n       synchronous active-low reset
//   btn_mode    raw mode button (async, active-high)
//   btn_inc     raw increment button (async, active-high)
//   sec/min     6-bit binary seconds/minutes, 0..59
//   hour        6-bit binary hours, 0..23 (1..12 when CLOCK_HOUR12_EN is defined)
//   mode        0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
//   sec_tick    one-cycle pulse on each RUN-mode second increment
//   pm          PM flag in 12-hour builds, constant 0 otherwise
//
// Build option: define CLOCK_HOUR12_EN for 12-hour counting with a PM flag.

module clock_timekeeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DEBOUNCE_MS   = 20
) (
  input  logic       clk_1000hz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       pm
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (DEBOUNCE_MS > 2) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_MS - 1);

`ifdef CLOCK_HOUR12_EN
  localparam logic [5:0] HOUR_RST = 6'd12;
`else
  localparam logic [5:0] HOUR_RST = 6'd0;
`endif

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  mode_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 = mode, index 1 = inc.
  // Each button has a 2-FF synchronizer, a debounce counter and an accepted
  // level. The press pulse is registered on the same edge the accepted level
  // rises, so it is visible one cycle after acceptance.
  // ---------------------------------------------------------------------------
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    btn_lvl;
  logic [1:0]    btn_press;
  logic [DW-1:0] db_cnt [2];

  assign btn_raw = {btn_inc, btn_mode};

  always_ff @(posedge clk_1000hz) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_lvl   <= '0;
      btn_press <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          // Level has differed long enough: accept it. Only a rising
          // acceptance produces a press; releases are silent.
          btn_lvl[i]   <= sync2[i];
          btn_press[i] <= sync2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic mode_press;
  logic inc_press;

  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1];

  // ---------------------------------------------------------------------------
  // Single-step successors for each field (wrapping, no carry).
  // ---------------------------------------------------------------------------
  logic [5:0] sec_inc;
  logic [5:0] min_inc;
  logic [5:0] hour_inc;

  always_comb begin
    sec_inc = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
    min_inc = (min == 6'd59) ? 6'd0 : min + 6'd1;
`ifdef CLOCK_HOUR12_EN
    hour_inc = (hour == 6'd12) ? 6'd1 : hour + 6'd1;
`else
    hour_inc = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, prescaler and time next-state.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_d, min_d, hour_d;
  logic          tick_d;
  logic          hour_adv;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec;
    min_d    = min;
    hour_d   = hour;
    tick_d   = 1'b0;
    hour_adv = 1'b0;

    case (state_q)
      RUN: begin
        if (mode_press) begin
          // A mode press on the wrap edge suppresses that second entirely.
          state_d = SET_HOUR;
          presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sec_d   = sec_inc;
          if (sec == 6'd59) begin
            min_d = min_inc;
            if (min == 6'd59) begin
              hour_adv = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      SET_HOUR: begin
        presc_d = '0;
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (inc_press) begin
          hour_adv = 1'b1;
        end
      end

      SET_MIN: begin
        presc_d = '0;
        if (mode_press) begin
          state_d = SET_SEC;
        end else if (inc_press) begin
          min_d = min_inc;
        end
      end

      SET_SEC: begin
        // Prescaler is already 0 here, so RUN starts a full second.
        presc_d = '0;
        if (mode_press) begin
          state_d = RUN;
        end else if (inc_press) begin
          sec_d = sec_inc;
        end
      end

      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase

    if (hour_adv) begin
      hour_d = hour_inc;
    end
  end

  always_ff @(posedge clk_1000hz) begin
    if (!rst_n) begin
      state_q  <= RUN;
      presc_q  <= '0;
      sec      <= 6'd0;
      min      <= 6'd0;
      hour     <= HOUR_RST;
      sec_tick <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec      <= sec_d;
      min      <= min_d;
      hour     <= hour_d;
      sec_tick <= tick_d;
    end
  end

  assign mode = state_q;

`ifdef CLOCK_HOUR12_EN
  // PM flips on every 11->12 step, whether from a carry or a set-mode inc.
  always_ff @(posedge clk_1000hz) begin
    if (!rst_n) begin
      pm <= 1'b0;
    end else if (hour_adv && (hour == 6'd11)) begin
      pm <= ~pm;
    end
  end
`else
  assign pm = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Range checks on the registered outputs.
  // ---------------------------------------------------------------------------
  a_sec_range: assert property (@(posedge clk_1000hz) disable iff (!rst_n) sec <= 6'd59);
  a_min_range: assert property (@(posedge clk_1000hz) disable iff (!rst_n) min <= 6'd59);
`ifdef CLOCK_HOUR12_EN
  a_hour_range: assert property (@(posedge clk_1000hz) disable iff (!rst_n)
                                 (hour >= 6'd1) && (hour <= 6'd12));
`else
  a_hour_range: assert property (@(posedge clk_1000hz) disable iff (!rst_n) hour <= 6'd23);
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Purpose : Scoreboard bench for clock_timekeeper (TICKS_PER_SEC=4, DEBOUNCE_MS=3).
// Latency : expected events carry the exact clock cycle at which they must appear.
// Backpressure: none; the monitor checks every output event as it happens.

module tb_clock_timekeeper;

  logic       clk_1000hz = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic [1:0] mode;
  logic       sec_tick;
  logic       pm;

  clock_timekeeper #(
    .TICKS_PER_SEC(4),
    .DEBOUNCE_MS  (3)
  ) dut (
    .clk_1000hz(clk_1000hz),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .mode      (mode),
    .sec_tick  (sec_tick),
    .pm        (pm)
  );

  always #5 clk_1000hz = ~clk_1000hz;

  localparam logic [1:0] BM  = 2'b01;  // mode button
  localparam logic [1:0] BI  = 2'b10;  // inc button
  localparam logic [1:0] BMI = 2'b11;  // both together

  typedef struct {
    int         at;
    logic [5:0] s;
    logic [5:0] m;
    logic [5:0] h;
    logic [1:0] md;
    logic       tk;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Cycle count = number of rising edges so far; rst_edge = reset seen at last edge.
  always @(posedge clk_1000hz) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  task automatic exp_push(input int at, input logic [5:0] s, m, h,
                          input logic [1:0] md, input logic tk, input logic p);
    exp_t e;
    e.at = at; e.s = s; e.m = m; e.h = h; e.md = md; e.tk = tk; e.p = p;
    exp_q.push_back(e);
  endtask

  // Button held high 4 cycles; the resulting event lands 6 edges after the raise.
  task automatic press(input logic [1:0] mask, input logic [5:0] s, m, h,
                       input logic [1:0] md, input logic p);
    exp_push(cyc + 6, s, m, h, md, 1'b0, p);
    {btn_inc, btn_mode} = mask;
    repeat (4) @(negedge clk_1000hz);
    {btn_inc, btn_mode} = 2'b00;
  endtask

  // Press plus enough idle time for the release to be debounced.
  task automatic pr(input logic [1:0] mask, input logic [5:0] s, m, h,
                    input logic [1:0] md, input logic p);
    press(mask, s, m, h, md, p);
    repeat (8) @(negedge clk_1000hz);
  endtask

  // From SET_HOUR with min=0: set min=59, sec=59, then return to RUN.
  // e = cycle at which mode becomes RUN.
  task automatic run_from_set_hour(input logic [5:0] s0, h, input logic p, output int e);
    pr(BM, s0, 6'd0, h, 2'd2, p);
    for (int i = 1; i <= 59; i++) pr(BI, s0, 6'(i), h, 2'd2, p);
    pr(BM, s0, 6'd59, h, 2'd3, p);
    for (int i = int'(s0) + 1; i <= 59; i++) pr(BI, 6'(i), 6'd59, h, 2'd3, p);
    press(BM, 6'd59, 6'd59, h, 2'd0, p);
    e = cyc + 2;
  endtask

  // Monitor: an output event is a reset edge, a sec_tick, or any field change.
  initial begin
    exp_t       e;
    logic [20:0] obs;
    logic [20:0] prev_obs;
    prev_obs = '0;
    forever begin
      @(negedge clk_1000hz);
      obs = {sec, min, hour, mode, pm};
      if (rst_edge || (sec_tick === 1'b1) || (obs !== prev_obs)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d got %0d:%0d:%0d mode=%0d tick=%b pm=%b, required no event",
                   cyc, hour, min, sec, mode, sec_tick, pm);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.at || sec !== e.s || min !== e.m || hour !== e.h ||
              mode !== e.md || sec_tick !== e.tk || pm !== e.p) begin
            miscompares++;
            $display("FAIL event_at_%0d got cyc=%0d %0d:%0d:%0d mode=%0d tick=%b pm=%b, required cyc=%0d %0d:%0d:%0d mode=%0d tick=%b pm=%b",
                     e.at, cyc, hour, min, sec, mode, sec_tick, pm,
                     e.at, e.h, e.m, e.s, e.md, e.tk, e.p);
          end
        end
      end
      prev_obs = obs;
    end
  end

  initial begin
    int   e;
    exp_t x;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

`ifdef CLOCK_HOUR12_EN
    exp_push(1, 0, 0, 12, 0, 0, 0);
    exp_push(2, 0, 0, 12, 0, 0, 0);
    repeat (2) @(negedge clk_1000hz);
    rst_n = 1'b1;
    exp_push(6, 1, 0, 12, 0, 1, 0);
    press(BM, 6'd1, 6'd0, 6'd12, 2'd1, 1'b0);  // mode change at edge 8
    repeat (8) @(negedge clk_1000hz);
    for (int h = 1; h <= 11; h++) pr(BI, 6'd1, 6'd0, 6'(h), 2'd1, 1'b0);
    run_from_set_hour(6'd1, 6'd11, 1'b0, e);
    exp_push(e + 4, 0, 0, 12, 0, 1, 1);       // 11:59:59 -> 12:00:00 PM
    repeat (8) @(negedge clk_1000hz);
    exp_push(e + 8, 1, 0, 12, 0, 1, 1);
    press(BM, 6'd1, 6'd0, 6'd12, 2'd1, 1'b1);
    repeat (8) @(negedge clk_1000hz);
    run_from_set_hour(6'd1, 6'd12, 1'b1, e);
    exp_push(e + 4, 0, 0, 1, 0, 1, 1);        // 12:59:59 -> 1:00:00, pm held
    repeat (8) @(negedge clk_1000hz);
`else
    exp_push(1, 0, 0, 0, 0, 0, 0);
    exp_push(2, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_1000hz);
    rst_n = 1'b1;
    // RUN from reset: ticks every 4 edges starting 4 edges after release.
    for (int k = 1; k <= 7; k++) exp_push(2 + 4 * k, 6'(k), 0, 0, 0, 1, 0);
    repeat (16) @(negedge clk_1000hz);         // cyc 18
    // 2-cycle glitch on mode: must be ignored.
    btn_mode = 1'b1;
    repeat (2) @(negedge clk_1000hz);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk_1000hz);          // cyc 28
    // Held 10 cycles: first sample at edge 29, press acts at edge 34, which
    // is also a prescaler wrap; mode wins, sec stays 7, no tick.
    exp_push(34, 7, 0, 0, 1, 0, 0);
    btn_mode = 1'b1;
    repeat (10) @(negedge clk_1000hz);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk_1000hz);
    for (int h = 1; h <= 5; h++) pr(BI, 6'd7, 6'd0, 6'(h), 2'd1, 1'b0);
    pr(BMI, 6'd7, 6'd0, 6'd5, 2'd2, 1'b0);      // both at once: mode wins
    for (int i = 1; i <= 59; i++) pr(BI, 6'd7, 6'(i), 6'd5, 2'd2, 1'b0);
    pr(BI, 6'd7, 6'd0, 6'd5, 2'd2, 1'b0);       // min 59 -> 0, no carry
    for (int i = 1; i <= 59; i++) pr(BI, 6'd7, 6'(i), 6'd5, 2'd2, 1'b0);
    pr(BM, 6'd7, 6'd59, 6'd5, 2'd3, 1'b0);
    for (int i = 8; i <= 59; i++) pr(BI, 6'(i), 6'd59, 6'd5, 2'd3, 1'b0);
    press(BM, 6'd59, 6'd59, 6'd5, 2'd0, 1'b0);
    e = cyc + 2;
    exp_push(e + 4, 0, 0, 6, 0, 1, 0);          // first tick 4 cycles after RUN
    repeat (8) @(negedge clk_1000hz);
    exp_push(e + 8, 1, 0, 6, 0, 1, 0);
    press(BM, 6'd1, 6'd0, 6'd6, 2'd1, 1'b0);    // lands on wrap edge e+12
    repeat (8) @(negedge clk_1000hz);
    for (int h = 7; h <= 23; h++) pr(BI, 6'd1, 6'd0, 6'(h), 2'd1, 1'b0);
    run_from_set_hour(6'd1, 6'd23, 1'b0, e);
    exp_push(e + 4, 0, 0, 0, 0, 1, 0);          // 23:59:59 -> 00:00:00
    repeat (8) @(negedge clk_1000hz);
`endif

    @(negedge clk_1000hz);
    #1;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event got nothing by cyc=%0d, required cyc=%0d %0d:%0d:%0d mode=%0d tick=%b",
               cyc, x.at, x.h, x.m, x.s, x.md, x.tk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
